// File: rtl/hazard_scoreboard_if.sv
// Bundle of ID-stage hazard query signals and the scoreboard's stall/forwarding answers.
// The master side is the pipeline controller, the slave side is the scoreboard.
interface hazard_scoreboard_if #(
    parameter int AW    = 5,
    parameter int DEPTH = 3,
    parameter int CW    = 32
);
    localparam int FW = $clog2(DEPTH + 1);

    logic          id_valid;
    logic [AW-1:0] id_rs;
    logic [AW-1:0] id_rt;
    logic          id_use_rs;
    logic          id_use_rt;
    logic          id_branch;
    logic          id_taken;
    logic          id_wr;
    logic [AW-1:0] id_wd;
    logic          id_load;
    logic          cnt_clr;

    logic          stall;
    logic          if_flush;
    logic [FW-1:0] id_fwd_rs;
    logic [FW-1:0] id_fwd_rt;
    logic [FW-1:0] ex_fwd_rs;
    logic [FW-1:0] ex_fwd_rt;
    logic [CW-1:0] stall_cnt;

    modport master (
        output id_valid, id_rs, id_rt, id_use_rs, id_use_rt, id_branch, id_taken,
               id_wr, id_wd, id_load, cnt_clr,
        input  stall, if_flush, id_fwd_rs, id_fwd_rt, ex_fwd_rs, ex_fwd_rt, stall_cnt
    );

    modport slave (
        input  id_valid, id_rs, id_rt, id_use_rs, id_use_rt, id_branch, id_taken,
               id_wr, id_wd, id_load, cnt_clr,
        output stall, if_flush, id_fwd_rs, id_fwd_rt, ex_fwd_rs, ex_fwd_rt, stall_cnt
    );
endinterface

// File: rtl/hazard_scoreboard.sv
// Tracks in-flight register writes in the post-ID slots and decides ID stalls,
// IF flushes and operand forwarding sources for the ID compare and the EX stage.
module hazard_scoreboard #(
    parameter int AW      = 5,
    parameter int DEPTH   = 3,
    parameter int LD_RDY  = 2,
    parameter int ALU_RDY = 1,
    parameter int CW      = 32
) (
    input  logic clk,
    input  logic rst,
    hazard_scoreboard_if.slave bus
);
    localparam int FW = $clog2(DEPTH + 1);

    logic [DEPTH-1:0] v_q, v_d;
    logic [AW-1:0]    wd_q  [DEPTH];
    logic [AW-1:0]    wd_d  [DEPTH];
    logic [FW-1:0]    rdy_q [DEPTH];
    logic [FW-1:0]    rdy_d [DEPTH];
    logic [FW-1:0]    ex_fwd_rs_q, ex_fwd_rs_d;
    logic [FW-1:0]    ex_fwd_rt_q, ex_fwd_rt_d;
    logic [CW-1:0]    stall_cnt_q, stall_cnt_d;

    logic [DEPTH-1:0] m_rs, m_rt, late;
    logic             rs_hit, rt_hit, hz_rs, hz_rt, stall;
    int               rs_k, rt_k;

    // late[k]: a producer sitting in slot k cannot yet feed this consumer.
    // Branches compare in ID, one stage earlier than EX, so they need one more slot.
    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_match
        assign m_rs[gi] = bus.id_valid & bus.id_use_rs & (bus.id_rs != '0) &
                          v_q[gi] & (wd_q[gi] == bus.id_rs);
        assign m_rt[gi] = bus.id_valid & bus.id_use_rt & (bus.id_rt != '0) &
                          v_q[gi] & (wd_q[gi] == bus.id_rt);
        assign late[gi] = bus.id_branch ? (gi < int'(rdy_q[gi]))
                                        : ((gi + 1) < int'(rdy_q[gi]));
    end

    // Youngest (lowest index) match wins, so scan from oldest down.
    always_comb begin
        rs_hit = 1'b0;
        rt_hit = 1'b0;
        rs_k   = 0;
        rt_k   = 0;
        for (int k = DEPTH - 1; k >= 0; k--) begin
            if (m_rs[k]) begin
                rs_hit = 1'b1;
                rs_k   = k;
            end
            if (m_rt[k]) begin
                rt_hit = 1'b1;
                rt_k   = k;
            end
        end
    end

    assign hz_rs = rs_hit & late[rs_k];
    assign hz_rt = rt_hit & late[rt_k];
    assign stall = hz_rs | hz_rt;

    assign bus.stall     = stall;
    assign bus.if_flush  = bus.id_valid & bus.id_branch & bus.id_taken & ~stall;
    assign bus.id_fwd_rs = (rs_hit && !stall) ? FW'(rs_k + 1) : '0;
    assign bus.id_fwd_rt = (rt_hit && !stall) ? FW'(rt_k + 1) : '0;
    assign bus.ex_fwd_rs = ex_fwd_rs_q;
    assign bus.ex_fwd_rt = ex_fwd_rt_q;
    assign bus.stall_cnt = stall_cnt_q;

    // Slot 0 takes the ID instruction, or a bubble while ID is held.
    assign v_d[0]   = stall ? 1'b0 : (bus.id_valid & bus.id_wr & (bus.id_wd != '0));
    assign wd_d[0]  = bus.id_wd;
    assign rdy_d[0] = bus.id_load ? FW'(LD_RDY) : FW'(ALU_RDY);

    for (genvar gi = 1; gi < DEPTH; gi++) begin : g_shift
        assign v_d[gi]   = v_q[gi-1];
        assign wd_d[gi]  = wd_q[gi-1];
        assign rdy_d[gi] = rdy_q[gi-1];
    end

    // After the edge the producer moves one slot older, hence k+2; one that
    // leaves the last slot has already reached the regfile.
    always_comb begin
        ex_fwd_rs_d = '0;
        ex_fwd_rt_d = '0;
        if (!stall) begin
            if (rs_hit && (rs_k + 1 < DEPTH)) ex_fwd_rs_d = FW'(rs_k + 2);
            if (rt_hit && (rt_k + 1 < DEPTH)) ex_fwd_rt_d = FW'(rt_k + 2);
        end
    end

    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if (bus.cnt_clr)
            stall_cnt_d = '0;
        else if (stall && (stall_cnt_q != {CW{1'b1}}))
            stall_cnt_d = stall_cnt_q + 1'b1;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            v_q         <= '0;
            ex_fwd_rs_q <= '0;
            ex_fwd_rt_q <= '0;
            stall_cnt_q <= '0;
            for (int k = 0; k < DEPTH; k++) begin
                wd_q[k]  <= '0;
                rdy_q[k] <= '0;
            end
        end else begin
            v_q         <= v_d;
            ex_fwd_rs_q <= ex_fwd_rs_d;
            ex_fwd_rt_q <= ex_fwd_rt_d;
            stall_cnt_q <= stall_cnt_d;
            for (int k = 0; k < DEPTH; k++) begin
                wd_q[k]  <= wd_d[k];
                rdy_q[k] <= rdy_d[k];
            end
        end
    end
endmodule

// File: doc/hazard_scoreboard.md
HAZARD_SCOREBOARD -- requirements
Module: hazard_scoreboard

Interface
REQ-001 SHALL have parameter AW, default 5, register address width.
REQ-002 SHALL have parameter DEPTH, default 3, tracked post-ID slots (0=EX, 1=MEM, 2=WB).
REQ-003 SHALL have parameter LD_RDY, default 2, first slot index at which load result is forwardable; legal range ALU_RDY..DEPTH-1.
REQ-004 SHALL have parameter ALU_RDY, default 1, first slot index at which ALU result is forwardable.
REQ-005 SHALL have parameter CW, default 32, stall-counter width.
REQ-006 SHALL have ports:
- clk  in  1  clock, rising edge.
- rst  in  1  reset; asynchronous, active-high.
- id_valid  in  1  ID holds a real instruction.
- id_rs, id_rt  in  AW  ID source addresses.
- id_use_rs, id_use_rt  in  1  source actually read.
- id_branch  in  1  beq/bne, compared in ID.
- id_taken  in  1  ID branch outcome.
- id_wr  in  1  ID instruction writes a register.
- id_wd  in  AW  ID destination address.
- id_load  in  1  ID instruction is a load.
- cnt_clr  in  1  synchronous clear of stall_cnt.
- stall  out  1  hold PC/IF-ID, inject bubble into EX.
- if_flush  out  1  squash IF instruction.
- id_fwd_rs, id_fwd_rt  out  $clog2(DEPTH+1)  ID-compare operand source: 0=regfile, k+1=slot k.
- ex_fwd_rs, ex_fwd_rt  out  $clog2(DEPTH+1)  registered EX operand source, same encoding.
- stall_cnt  out  CW  cycles with stall=1.

Function
REQ-007 SHALL hold DEPTH entries {v, wd, rdy}; rdy=LD_RDY if id_load else ALU_RDY.
REQ-008 Each rising edge SHALL shift slot k to k+1 and drop slot DEPTH-1.
REQ-009 Slot 0 SHALL load {id_valid&id_wr&(id_wd!=0), id_wd, rdy} when stall=0, else v=0 (bubble).
REQ-010 Match of source s to slot k SHALL require id_valid, use bit, s!=0, v[k], wd[k]==s.
REQ-011 Only the lowest-index (youngest) matching slot SHALL be considered per source.
REQ-012 Branch case (id_branch=1): source hazard SHALL be youngest match k with k<rdy[k].
REQ-013 Non-branch case: source hazard SHALL be youngest match k with k+1<rdy[k].
REQ-014 stall SHALL be combinational OR of rs and rt hazards.
REQ-015 id_fwd_x SHALL be k+1 for a non-hazard youngest match, else 0; value 0 when stall=1.
REQ-016 if_flush SHALL equal id_valid&id_branch&id_taken&~stall.
REQ-017 On edge with stall=0: ex_fwd_x SHALL register k+2 if youngest match k satisfies k+1<DEPTH, else 0.
REQ-018 On edge with stall=1: ex_fwd_x SHALL register 0.
REQ-019 Matches beyond slot DEPTH-1 SHALL read regfile (write-before-read regfile).
REQ-020 stall_cnt SHALL increment on stall=1 and saturate at all-ones.
REQ-021 cnt_clr SHALL zero stall_cnt, with priority over increment.
REQ-022 Simultaneous rs and rt hazards SHALL count once.
REQ-023 rs==rt SHALL produce identical fwd codes for both.
REQ-024 A stalled instruction SHALL re-evaluate each cycle, with stall deasserting the first cycle no hazard remains.

Reset
REQ-025 rst=1 SHALL asynchronously clear all v, ex_fwd_rs/rt, stall_cnt; combinational outputs then read 0.
REQ-026 Reset mid-stall SHALL release stall in the same cycle; no pending entry SHALL survive.
REQ-027 First edge after rst falls SHALL behave as an empty pipeline.

Verification
REQ-028 Load r5 issued, next cycle add r6,r5,r1 in ID -> stall=1 for 1 cycle, then ex_fwd_rs=3 (WB), stall_cnt=1.
REQ-029 Add r5 issued, next cycle beq r5,r2 in ID -> stall=1 one cycle; next cycle id_fwd_rs=2 (MEM), if_flush=id_taken.
REQ-030 Load r5, then beq r5,r5 in ID -> stall=1 two cycles, then id_fwd_rs=id_fwd_rt=3.
REQ-031 Write r0 from load, then consumer of r0 -> stall=0, all fwd codes 0.
REQ-032 Two in-flight writes to r7 (slots 0 and 1), ALU consumer -> youngest used, ex_fwd_rs=2.
REQ-033 rst pulsed while stall=1, stall_cnt=9 -> stall=0, stall_cnt=0 immediately; cnt_clr with stall=1 -> stall_cnt=0.
